// File: rtl/c17_bist_controller.sv
// c17_bist_controller: LFSR pattern source and MISR response compactor for a C17-class CUT.
// Optional response bit-flip injection with first-failure capture: define C17_BIST_FAULT_INJ_EN.
module c17_bist_controller #(
  parameter int         NUM_PATTERNS = 31,
  parameter logic [4:0] LFSR_SEED    = 5'b00001,
  parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [4:0] pat_out,
  input  logic [1:0] resp_in,
`ifdef C17_BIST_FAULT_INJ_EN
  input  logic       inj_en,
  input  logic [1:0] inj_mask,
  output logic       first_fail_valid,
  output logic [4:0] first_fail_idx,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [4:0] pat_count
);
  // an all-zero seed would lock the LFSR
  localparam logic [4:0] SEED = (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
  localparam logic [4:0] NP   = 5'(NUM_PATTERNS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     r_state;
  logic [4:0] r_lfsr;
  logic [4:0] r_cnt;
  logic [7:0] r_misr;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [1:0] w_resp;
  logic [4:0] w_lfsr_nxt;
  logic [7:0] w_misr_nxt;
  logic       w_last;
`ifdef C17_BIST_FAULT_INJ_EN
  logic       r_ff_valid;
  logic [4:0] r_ff_idx;
  logic       w_inj;
  assign w_inj  = inj_en && |inj_mask;
  assign w_resp = resp_in ^ (inj_en ? inj_mask : 2'b00);
  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;
`else
  assign w_resp = resp_in;
`endif
  assign w_lfsr_nxt = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  assign w_misr_nxt = {r_misr[6:4], r_misr[3] ^ r_misr[7], r_misr[2] ^ r_misr[7],
                       r_misr[1] ^ r_misr[7], r_misr[0] ^ w_resp[1], r_misr[7] ^ w_resp[0]};
  assign w_last     = (r_cnt == NP - 5'd1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lfsr  <= SEED;
      r_misr  <= 8'h00;
      r_cnt   <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
`ifdef C17_BIST_FAULT_INJ_EN
      r_ff_valid <= 1'b0;
      r_ff_idx   <= 5'd0;
`endif
    end else begin
      case (r_state)
        RUN: begin
          // response for the current pattern is captured on the same edge the pattern advances
          r_misr <= w_misr_nxt;
          r_lfsr <= w_lfsr_nxt;
          if (r_cnt != NP) r_cnt <= r_cnt + 5'd1;
`ifdef C17_BIST_FAULT_INJ_EN
          if (w_inj && !r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_idx   <= r_cnt;
          end
`endif
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_misr_nxt == GOLDEN_SIG);
          end
        end
        default: if (start) begin
          r_state <= RUN;
          r_lfsr  <= SEED;
          r_misr  <= 8'h00;
          r_cnt   <= 5'd0;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
`ifdef C17_BIST_FAULT_INJ_EN
          r_ff_valid <= 1'b0;
          r_ff_idx   <= 5'd0;
`endif
        end
      endcase
    end
  end
  assign pat_out   = r_lfsr;
  assign signature = r_misr;
  assign pat_count = r_cnt;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
endmodule

// File: tb/tb_c17_bist_controller.sv
// tb_c17_bist_controller: scoreboard and vector-table checks of the C17 BIST controller
// against a behavioural C17 netlist, LFSR and polynomial-form MISR model.
module tb_c17_bist_controller;
  function automatic logic [1:0] c17_f(input logic [4:0] p);
    logic g10, g11, g16, g19;
    g10 = ~(p[0] & p[2]);
    g11 = ~(p[2] & p[3]);
    g16 = ~(p[1] & g11);
    g19 = ~(g11 & p[4]);
    return {~(g16 & g19), ~(g10 & g16)};
  endfunction
  function automatic logic [4:0] lfsr_f(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction
  // x^8+x^4+x^3+x^2+1 as shift-and-reduce with the response folded into the low bits
  function automatic logic [7:0] misr_f(input logic [7:0] m, input logic [1:0] r);
    return {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, r};
  endfunction
  function automatic logic [7:0] ref_sig(input int n, input int inj_idx, input logic [1:0] mask);
    logic [4:0] l;
    logic [7:0] m;
    logic [1:0] r;
    l = 5'd1;
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      r = c17_f(l);
      if (i == inj_idx) r = r ^ mask;
      m = misr_f(m, r);
      l = lfsr_f(l);
    end
    return m;
  endfunction
  localparam logic [7:0] REF31 = ref_sig(31, -1, 2'b00);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [4:0] pat0, pat1, pat2, cnt0, cnt1, cnt2;
  logic [7:0] sig0, sig1, sig2;
  logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [1:0] resp0;
  assign resp0 = c17_f(pat0);
`ifdef C17_BIST_FAULT_INJ_EN
  logic inj_en = 1'b0;
  logic [1:0] inj_mask = 2'b00;
  logic ffv0, ffv1, ffv2;
  logic [4:0] ffi0, ffi1, ffi2;
`endif

  c17_bist_controller #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(REF31)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pat_out(pat0), .resp_in(resp0),
`ifdef C17_BIST_FAULT_INJ_EN
    .inj_en(inj_en), .inj_mask(inj_mask), .first_fail_valid(ffv0), .first_fail_idx(ffi0),
`endif
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .pat_count(cnt0));
  c17_bist_controller #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(8'h00)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .pat_out(pat1), .resp_in(2'b00),
`ifdef C17_BIST_FAULT_INJ_EN
    .inj_en(1'b0), .inj_mask(2'b00), .first_fail_valid(ffv1), .first_fail_idx(ffi1),
`endif
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .pat_count(cnt1));
  c17_bist_controller #(.NUM_PATTERNS(4), .LFSR_SEED(5'b00000), .GOLDEN_SIG(8'h00)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .pat_out(pat2), .resp_in(2'b11),
`ifdef C17_BIST_FAULT_INJ_EN
    .inj_en(1'b0), .inj_mask(2'b00), .first_fail_valid(ffv2), .first_fail_idx(ffi2),
`endif
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .pat_count(cnt2));

  int total = 0;
  int bad = 0;
  typedef struct { logic [4:0] cnt; logic [7:0] sig; } vec_t;
  vec_t tab[4];
  logic [4:0] pat_tab[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run0(input int restart_at, output logic [7:0] fsig);
    logic [4:0] l;
    logic [7:0] m;
    logic [7:0] q[$];
    int i;
    l = 5'd1;
    m = 8'h00;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    i = 0;
    while (busy0 && i < 40) begin
      chk("pat_count", 32'(cnt0), i);
      chk("pat_out", 32'(pat0), 32'(l));
      if (i < 4) chk("pat_seq", 32'(pat0), 32'(pat_tab[i]));
      if (i == 0) chk("sig_start", 32'(sig0), 0);
      else if (q.size() != 0) chk("sig_step", 32'(sig0), 32'(q.pop_front()));
      m = misr_f(m, c17_f(l));
      q.push_back(m);
      l = lfsr_f(l);
      start0 = (i == restart_at);
      i++;
      @(negedge clk);
    end
    start0 = 1'b0;
    chk("busy_len", i, 31);
    chk("done", 32'(done0), 1);
    chk("final_count", 32'(cnt0), 31);
    if (q.size() == 0) chk("final_sig_missing", 32'(sig0), 32'hFFFF_FFFF);
    else chk("final_sig", 32'(sig0), 32'(q.pop_front()));
    chk("ref_sig", 32'(sig0), 32'(REF31));
    chk("pass", 32'(pass0), 1);
    fsig = sig0;
  endtask

  logic [7:0] s1, s2, s3;
  initial begin
    tab[0] = '{5'd1, 8'h03};
    tab[1] = '{5'd2, 8'h05};
    tab[2] = '{5'd3, 8'h09};
    tab[3] = '{5'd4, 8'h11};
    pat_tab[0] = 5'b00001;
    pat_tab[1] = 5'b00010;
    pat_tab[2] = 5'b00100;
    pat_tab[3] = 5'b01001;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pat", 32'(pat0), 1);
    chk("rst_sig", 32'(sig0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_flags", 32'({busy0, done0, pass0}), 0);
    chk("rst_zero_seed_pat", 32'(pat2), 1);
    rst_n = 1'b1;
    @(negedge clk);
    run0(10, s1);
    repeat (3) @(negedge clk);
    chk("hold_done", 32'(done0), 1);
    chk("hold_pat", 32'(pat0), 1);
    chk("hold_cnt", 32'(cnt0), 31);
    run0(-1, s2);
    chk("rerun_same", 32'(s2), 32'(s1));

    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int i = 0; i < 40 && busy1; i++) begin
      chk("zero_resp_sig", 32'(sig1), 0);
      @(negedge clk);
    end
    chk("zero_done", 32'({done1, pass1, busy1}), 32'b110);
    chk("zero_sig_final", 32'(sig1), 0);

    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    chk("np4_busy", 32'(busy2), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("np4_cnt", 32'(cnt2), 32'(tab[k].cnt));
      chk("np4_sig", 32'(sig2), 32'(tab[k].sig));
    end
    chk("np4_flags", 32'({busy2, done2, pass2}), 32'b010);
    repeat (3) @(negedge clk);
    chk("np4_sat", 32'(cnt2), 4);

    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_busy", 32'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", 32'({busy0, done0, pass0}), 0);
    chk("async_rst_sig", 32'(sig0), 0);
    chk("async_rst_cnt", 32'(cnt0), 0);
    chk("async_rst_pat", 32'(pat0), 1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run0(-1, s3);
    chk("after_rst_same", 32'(s3), 32'(s1));

`ifdef C17_BIST_FAULT_INJ_EN
    inj_mask = 2'b01;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int i = 0; i < 40 && busy0; i++) begin
      inj_en = (i == 7);
      @(negedge clk);
    end
    inj_en = 1'b0;
    chk("inj_sig", 32'(sig0), 32'(ref_sig(31, 7, 2'b01)));
    chk("inj_differs", 32'(sig0 != REF31), 1);
    chk("inj_pass", 32'(pass0), 0);
    chk("inj_ff_valid", 32'(ffv0), 1);
    chk("inj_ff_idx", 32'(ffi0), 7);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
